// File: rtl/psum_accum.sv
// PSUM accumulator: drains OFIFO vectors into PSUM SRAM, overwriting or accumulating.
// Define PSUM_ACC_SAT_EN to saturate lane sums instead of wrapping.
module psum_accum #(
    parameter int col    = 8,
    parameter int psum_bw = 16,
    parameter int ADDR_W = 11
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [ADDR_W-1:0]      base_addr,
    input  logic [ADDR_W-1:0]      num_vec,
    input  logic                   acc_mode,
    input  logic                   ofifo_valid,
    input  logic [psum_bw*col-1:0] ofifo_out,
    output logic                   ofifo_rd,
    output logic [ADDR_W-1:0]      psum_mem_addr,
    output logic                   psum_mem_rd,
    output logic                   psum_mem_wr,
    output logic [psum_bw*col-1:0] psum_mem_din,
    input  logic [psum_bw*col-1:0] psum_mem_dout,
    output logic                   busy,
    output logic                   done
);

    localparam int W = psum_bw * col;
`ifdef PSUM_ACC_SAT_EN
    localparam bit SatEn = 1'b1;
`else
    localparam bit SatEn = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, POP, RDWAIT, WR, DONE} state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] oaddr_q;
    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] nv_q;
    logic              acc_q;
    logic [W-1:0]      data_q;
    logic [W-1:0]      sum_d;
    logic              strobe;

    for (genvar g = 0; g < col; g++) begin : g_lane
        logic [psum_bw-1:0] a;
        logic [psum_bw-1:0] b;
        logic [psum_bw:0]   s;
        logic               ovf;
        assign a   = data_q[g*psum_bw +: psum_bw];
        assign b   = psum_mem_dout[g*psum_bw +: psum_bw];
        assign s   = {a[psum_bw-1], a} + {b[psum_bw-1], b};
        assign ovf = SatEn && (s[psum_bw] != s[psum_bw-1]);
        // Overflow direction follows the true (psum_bw+1)-bit sign.
        assign sum_d[g*psum_bw +: psum_bw] = ovf
            ? {s[psum_bw], {(psum_bw-1){~s[psum_bw]}}}
            : s[psum_bw-1:0];
    end

    assign ofifo_rd      = (state_q == POP) && ofifo_valid;
    assign psum_mem_rd   = ofifo_rd && acc_q;
    assign psum_mem_wr   = (state_q == WR);
    assign psum_mem_din  = data_q;
    assign busy          = (state_q != IDLE);
    assign done          = (state_q == DONE);
    assign strobe        = psum_mem_rd || psum_mem_wr;
    // Address bus only moves while a strobe is active.
    assign psum_mem_addr = strobe ? addr_q : oaddr_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            oaddr_q <= '0;
            cnt_q   <= '0;
            nv_q    <= '0;
            acc_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            if (strobe) oaddr_q <= addr_q;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        addr_q  <= base_addr;
                        nv_q    <= num_vec;
                        acc_q   <= acc_mode;
                        cnt_q   <= '0;
                        state_q <= (num_vec == '0) ? DONE : POP;
                    end
                end
                POP: begin
                    if (ofifo_valid) begin
                        data_q  <= ofifo_out;
                        state_q <= acc_q ? RDWAIT : WR;
                    end
                end
                RDWAIT: begin
                    data_q  <= sum_d;
                    state_q <= WR;
                end
                WR: begin
                    addr_q  <= addr_q + ADDR_W'(1);
                    cnt_q   <= cnt_q + ADDR_W'(1);
                    state_q <= (cnt_q == nv_q - ADDR_W'(1)) ? DONE : POP;
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_psum_accum.sv
// Bench for psum_accum: directed and random jobs against an SRAM/OFIFO model
// and a lane-arithmetic reference memory.
module tb_psum_accum;

    localparam int COL = 8;
    localparam int PB  = 16;
    localparam int AW  = 11;
    localparam int W   = COL * PB;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW-1:0] num_vec;
    logic          acc_mode;
    logic          ofifo_valid;
    logic [W-1:0]  ofifo_out;
    logic          ofifo_rd;
    logic [AW-1:0] psum_mem_addr;
    logic          psum_mem_rd;
    logic          psum_mem_wr;
    logic [W-1:0]  psum_mem_din;
    logic [W-1:0]  psum_mem_dout;
    logic          busy;
    logic          done;

    logic          bd_we;
    logic [AW-1:0] bd_addr;
    logic [W-1:0]  bd_data;

    logic [W-1:0]  sram    [0:2047];
    logic [W-1:0]  ref_mem [0:2047];
    logic [W-1:0]  job_vecs[$];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    psum_accum #(.col(COL), .psum_bw(PB), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .start(start),
        .base_addr(base_addr), .num_vec(num_vec), .acc_mode(acc_mode),
        .ofifo_valid(ofifo_valid), .ofifo_out(ofifo_out), .ofifo_rd(ofifo_rd),
        .psum_mem_addr(psum_mem_addr), .psum_mem_rd(psum_mem_rd),
        .psum_mem_wr(psum_mem_wr), .psum_mem_din(psum_mem_din),
        .psum_mem_dout(psum_mem_dout), .busy(busy), .done(done)
    );

    always @(posedge clk) begin
        if (psum_mem_rd) psum_mem_dout <= sram[psum_mem_addr];
        if (psum_mem_wr) sram[psum_mem_addr] <= psum_mem_din;
        if (bd_we) sram[bd_addr] <= bd_data;
    end

    function automatic logic [W-1:0] splat(input int v);
        logic [W-1:0] r;
        for (int i = 0; i < COL; i++) r[i*PB +: PB] = PB'(v);
        return r;
    endfunction

    function automatic logic [W-1:0] rnd_vec();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [W-1:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        int s;
        for (int i = 0; i < COL; i++) begin
            s = int'($signed(a[i*PB +: PB])) + int'($signed(b[i*PB +: PB]));
`ifdef PSUM_ACC_SAT_EN
            if (s > 2**(PB-1) - 1) s = 2**(PB-1) - 1;
            if (s < -(2**(PB-1))) s = -(2**(PB-1));
`endif
            r[i*PB +: PB] = PB'(s);
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_job(input logic [AW-1:0] base, input logic [AW-1:0] n,
                           input logic acc, input int st_at, input int st_len,
                           input int ign_at);
        logic [W-1:0]  fifo[$];
        logic [AW-1:0] exp_a[$];
        logic [W-1:0]  exp_d[$];
        logic [AW-1:0] wa[$];
        logic [AW-1:0] ra[$];
        logic [W-1:0]  wd[$];
        logic [W-1:0]  v;
        logic [AW-1:0] a;
        int lat, nrd, stall_rd, both, exp_lat;
        bit pop, stall;
        lat = -1; nrd = 0; stall_rd = 0; both = 0; pop = 0;
        for (int i = 0; i < int'(n); i++) begin
            v = (job_vecs.size() > 0) ? job_vecs.pop_front() : rnd_vec();
            fifo.push_back(v);
            a = base + AW'(i);
            ref_mem[a] = acc ? ref_add(ref_mem[a], v) : v;
            exp_a.push_back(a);
            exp_d.push_back(ref_mem[a]);
        end
        @(negedge clk);
        start = 1'b1; base_addr = base; num_vec = n; acc_mode = acc;
        ofifo_valid = 1'b0; ofifo_out = '0;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (pop) void'(fifo.pop_front());
            stall = (c >= st_at) && (c < st_at + st_len);
            start = (c == ign_at);
            base_addr = 11'd100; num_vec = 11'd7; acc_mode = ~acc;
            ofifo_valid = (fifo.size() > 0) && !stall;
            ofifo_out = (fifo.size() > 0) ? fifo[0] : '0;
            #1;
            pop = ofifo_rd;
            if (ofifo_rd) nrd++;
            if (stall && ofifo_rd) stall_rd++;
            if (psum_mem_rd) ra.push_back(psum_mem_addr);
            if (psum_mem_wr) begin
                wa.push_back(psum_mem_addr);
                wd.push_back(psum_mem_din);
            end
            if (psum_mem_rd && psum_mem_wr) both++;
            if (done) begin
                lat = c;
                break;
            end
        end
        @(negedge clk);
        start = 1'b0; ofifo_valid = 1'b0;
        #1;
        exp_lat = 1 + (acc ? 3 : 2) * int'(n) + st_len;
        chk("latency", lat, exp_lat);
        chk("done_one_cycle", done, 1'b0);
        chk("idle_after_done", busy, 1'b0);
        chk("ofifo_pops", nrd, int'(n));
        chk("stall_pops", stall_rd, 0);
        chk("rd_wr_overlap", both, 0);
        chk("num_writes", wa.size(), int'(n));
        chk("num_reads", ra.size(), acc ? int'(n) : 0);
        for (int i = 0; i < wa.size() && i < exp_a.size(); i++) begin
            chk($sformatf("wr_addr%0d", i), wa[i], exp_a[i]);
            chk($sformatf("wr_data%0d", i), wd[i], exp_d[i]);
        end
        for (int i = 0; i < ra.size() && i < exp_a.size(); i++)
            chk($sformatf("rd_addr%0d", i), ra[i], exp_a[i]);
    endtask

    logic [W-1:0] tv;

    initial begin
        reset = 1'b0; start = 1'b0; base_addr = '0; num_vec = '0;
        acc_mode = 1'b0; ofifo_valid = 1'b0; ofifo_out = '0;
        bd_we = 1'b0; bd_addr = '0; bd_data = '0;
        #1;
        chk("rst_ofifo_rd", ofifo_rd, 1'b0);
        chk("rst_mem_rd", psum_mem_rd, 1'b0);
        chk("rst_mem_wr", psum_mem_wr, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_addr", psum_mem_addr, '0);
        chk("rst_din", psum_mem_din, '0);

        for (int i = 0; i < 2048; i++) begin
            @(negedge clk);
            tv = rnd_vec();
            if (i == 10) tv = splat(100);
            if (i == 20) begin
                tv = splat(32767);
                tv[PB +: PB] = 16'h8000;
            end
            bd_we = 1'b1; bd_addr = AW'(i); bd_data = tv;
            ref_mem[i] = tv;
        end
        @(negedge clk);
        bd_we = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        job_vecs = '{splat(1), splat(2), splat(3)};
        run_job(11'd5, 11'd3, 1'b0, -1, 0, -1);

        job_vecs = '{splat(-30)};
        run_job(11'd10, 11'd1, 1'b1, -1, 0, -1);
        chk("acc_result_100m30", sram[10], splat(70));

        tv = splat(1);
        tv[PB +: PB] = 16'hFFFF;
        job_vecs = '{tv};
        run_job(11'd20, 11'd1, 1'b1, -1, 0, -1);
`ifdef PSUM_ACC_SAT_EN
        chk("lane0_overflow", sram[20][PB-1:0], 16'h7FFF);
        chk("lane1_underflow", sram[20][2*PB-1:PB], 16'h8000);
`else
        chk("lane0_overflow", sram[20][PB-1:0], 16'h8000);
        chk("lane1_underflow", sram[20][2*PB-1:PB], 16'h7FFF);
`endif

        run_job(11'd2046, 11'd3, 1'b0, 3, 5, 4);
        run_job(11'd2046, 11'd2, 1'b1, 4, 3, 5);

        run_job(11'd50, 11'd0, 1'b1, -1, 0, -1);

        @(negedge clk);
        start = 1'b1; base_addr = 11'd300; num_vec = 11'd2; acc_mode = 1'b1;
        @(negedge clk);
        start = 1'b0; ofifo_valid = 1'b1; ofifo_out = rnd_vec();
        #1;
        chk("pre_rst_pop", ofifo_rd, 1'b1);
        chk("pre_rst_rd", psum_mem_rd, 1'b1);
        @(negedge clk);
        ofifo_valid = 1'b0;
        #1;
        chk("pre_rst_busy", busy, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_ofifo_rd", ofifo_rd, 1'b0);
        chk("mid_rst_mem_rd", psum_mem_rd, 1'b0);
        chk("mid_rst_mem_wr", psum_mem_wr, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_done", done, 1'b0);
        chk("mid_rst_addr", psum_mem_addr, '0);
        chk("mid_rst_din", psum_mem_din, '0);
        @(negedge clk);
        reset = 1'b1;
        run_job(11'd300, 11'd2, 1'b1, -1, 0, -1);

        for (int k = 0; k < 6; k++) begin
            run_job(AW'($urandom), AW'($urandom_range(1, 6)),
                    1'($urandom), -1, 0, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/psum_accum.md
PSUM_ACCUM -- requirements
Module: psum_accum

Interface
REQ-001 SHALL have parameter col, default 8: PSUM lanes per vector.
REQ-002 SHALL have parameter psum_bw, default 16: signed two's-complement bits per lane.
REQ-003 SHALL have parameter ADDR_W, default 11: PSUM SRAM address width.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state on rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port start, input, 1 bit: one-cycle job launch pulse.
REQ-007 SHALL have port base_addr, input, ADDR_W bits: first SRAM address; sampled on accepted start.
REQ-008 SHALL have port num_vec, input, ADDR_W bits: vectors in the job; sampled on accepted start.
REQ-009 SHALL have port acc_mode, input, 1 bit: 1 adds to SRAM contents, 0 overwrites; sampled on accepted start.
REQ-010 SHALL have port ofifo_valid, input, 1 bit: OFIFO holds a vector.
REQ-011 SHALL have port ofifo_out, input, psum_bw*col bits: OFIFO head vector, show-ahead.
REQ-012 SHALL have port ofifo_rd, output, 1 bit: OFIFO pop.
REQ-013 SHALL have port psum_mem_addr, output, ADDR_W bits: SRAM address.
REQ-014 SHALL have port psum_mem_rd, output, 1 bit: SRAM read strobe.
REQ-015 SHALL have port psum_mem_wr, output, 1 bit: SRAM write strobe.
REQ-016 SHALL have port psum_mem_din, output, psum_bw*col bits: SRAM write data.
REQ-017 SHALL have port psum_mem_dout, input, psum_bw*col bits: SRAM read data, valid exactly 1 cycle after psum_mem_rd.
REQ-018 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-019 SHALL have port done, output, 1 bit: one-cycle job-complete pulse.

Function
REQ-020 SHALL implement FSM states IDLE, POP, RDWAIT, WR, DONE.
REQ-021 IDLE: start=1 SHALL latch base_addr, num_vec and acc_mode, clear the vector counter, and go to POP; if num_vec=0, SHALL go to DONE instead.
REQ-022 start SHALL be ignored in every state except IDLE.
REQ-023 POP with ofifo_valid=0 SHALL hold the state with ofifo_rd=0.
REQ-024 POP with ofifo_valid=1 SHALL assert ofifo_rd combinationally for exactly that cycle and capture ofifo_out into the data register.
REQ-025 In that same POP cycle with acc_mode=1, SHALL also assert psum_mem_rd at the current address and go to RDWAIT.
REQ-026 In that same POP cycle with acc_mode=0, SHALL go to WR.
REQ-027 RDWAIT: SHALL add psum_mem_dout to the captured vector lane-wise, signed, per REQ-035, register the result, and go to WR.
REQ-028 WR: SHALL assert psum_mem_wr for exactly one cycle, with psum_mem_din equal to the registered result and psum_mem_addr equal to the current address.
REQ-029 WR: SHALL increment the address and counter; when counter equals num_vec-1, SHALL go to DONE, otherwise to POP.
REQ-030 DONE: SHALL assert done for one cycle and return to IDLE.
REQ-031 psum_mem_rd and psum_mem_wr SHALL never both be high; psum_mem_addr SHALL hold its last value outside strobes.
REQ-032 Address SHALL wrap modulo 2^ADDR_W.
REQ-033 Throughput SHALL be 3 cycles per vector with acc_mode=1 and 2 cycles with acc_mode=0, given continuous ofifo_valid.
REQ-034 Latency from accepted start to done SHALL be 1+3N cycles (acc_mode=1) or 1+2N cycles (acc_mode=0), given continuous ofifo_valid.
REQ-035 Lane sums SHALL be computed at psum_bw+1 bits and reduced to psum_bw bits per Configuration.

Reset
REQ-036 Asserting reset (low) SHALL force IDLE immediately, with no clock needed.
REQ-037 Asserting reset SHALL drive ofifo_rd, psum_mem_rd, psum_mem_wr, busy and done to 0, and psum_mem_addr, psum_mem_din and all registers to 0.
REQ-038 Reset mid-job SHALL abandon the job with no rollback of completed SRAM writes; the next start SHALL behave as a fresh job.

Configuration
REQ-039 With macro PSUM_ACC_SAT_EN defined, lane sums SHALL saturate to [-2^(psum_bw-1), 2^(psum_bw-1)-1].
REQ-040 With PSUM_ACC_SAT_EN undefined, lane sums SHALL wrap modulo 2^psum_bw.
REQ-041 PSUM_ACC_SAT_EN SHALL NOT affect acc_mode=0 data or any timing.

Verification
REQ-042 Scenario: acc_mode=0, base=5, num_vec=3, OFIFO vectors of all lanes 1, 2, 3 -> writes to 5, 6, 7 with those values; done exactly 7 cycles after start.
REQ-043 Scenario: acc_mode=1, SRAM[10] all lanes 100, OFIFO all lanes -30 -> rd at 10, next cycle wr 10 with all lanes 70; done exactly 4 cycles after start.
REQ-044 Scenario: lane 0 = 32767 + 1 -> 32767 with PSUM_ACC_SAT_EN defined; -32768 without.
REQ-045 Scenario: base=2046, num_vec=3, ofifo_valid low 5 cycles mid-job -> writes to 2046, 2047, 0; POP stalls with ofifo_rd=0; start pulsed while busy is ignored.
REQ-046 Scenario: num_vec=0 -> done exactly 1 cycle after start, with no ofifo_rd or SRAM strobes.
REQ-047 Scenario: reset low in RDWAIT -> all outputs 0 immediately; a new job afterwards completes correctly.
